// File: rtl/trap_arbiter.sv
// trap_arbiter
// Machine-mode trap controller. Picks one trap per cycle from NUM_EXC
// synchronous exception sources and the three machine interrupts
// (MEI > MSI > MTI). On capture it commits mepc/mcause/mtval/mstatus and
// presents the handler address to fetch through a valid/ack handshake.
// It also owns the trap CSRs behind a single-cycle CSR port.
//
// Ports
//   clk_in         clock (single domain)
//   rst_in         synchronous active-high reset
//   exc_req_in     exception requests, bit i = cause i, lowest index wins
//   epc_in         PC of the faulting / interrupted instruction
//   tval_in        trap value accompanying exc_req_in
//   irq_in         level interrupts {meip, mtip, msip}
//   mret_in        one-cycle MRET retire pulse
//   csr_we_in      CSR write strobe
//   csr_addr_in    CSR address (read and write)
//   csr_wdata_in   CSR write data
//   csr_rdata_out  combinational CSR read data, 0 for unmapped addresses
//   trap_ack_in    fetch accepted trap_pc_out
//   trap_valid_out trap redirect pending
//   trap_pc_out    handler address, held until the next capture
//   mret_pc_out    current mepc
//   busy_out       high while a redirect is pending (pipeline stall)
module trap_arbiter #(
  parameter int              XLEN        = 32,
  parameter int              NUM_EXC     = 12,
  parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [NUM_EXC-1:0] exc_req_in,
  input  logic [XLEN-1:0]    epc_in,
  input  logic [XLEN-1:0]    tval_in,
  input  logic [2:0]         irq_in,
  input  logic               mret_in,
  input  logic               csr_we_in,
  input  logic [11:0]        csr_addr_in,
  input  logic [XLEN-1:0]    csr_wdata_in,
  output logic [XLEN-1:0]    csr_rdata_out,
  input  logic               trap_ack_in,
  output logic               trap_valid_out,
  output logic [XLEN-1:0]    trap_pc_out,
  output logic [XLEN-1:0]    mret_pc_out,
  output logic               busy_out
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  typedef enum logic {IDLE, REQ} state_t;

  state_t state_q, state_d;

  logic            mstatus_mie_q;
  logic            mstatus_mpie_q;
  logic [2:0]      mie_q;          // {meie, mtie, msie}
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mtval_q;
  logic [XLEN-1:0] trap_pc_q;

  logic            exc_any;
  logic [4:0]      exc_code;
  logic [2:0]      irq_pend;
  logic            irq_take;
  logic [4:0]      irq_code;
  logic            take_trap;
  logic            take_irq;
  logic            do_mret;
  logic [XLEN-1:0] trap_target;

  logic wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause, wr_mtval;

  // Lowest set request index wins; scanning downward leaves the lowest.
  always_comb begin
    exc_any  = 1'b0;
    exc_code = '0;
    for (int i = NUM_EXC - 1; i >= 0; i--) begin
      if (exc_req_in[i]) begin
        exc_any  = 1'b1;
        exc_code = 5'(i);
      end
    end
  end

  // Interrupt order is MEI > MSI > MTI, which is not numeric cause order.
  assign irq_pend = mie_q & irq_in;
  assign irq_take = mstatus_mie_q && (irq_pend != 3'b000);

  always_comb begin
    irq_code = 5'd7;
    if (irq_pend[2])      irq_code = 5'd11;
    else if (irq_pend[0]) irq_code = 5'd3;
  end

  // Next-state and trap decision
  always_comb begin
    state_d   = state_q;
    take_trap = 1'b0;
    take_irq  = 1'b0;
    do_mret   = 1'b0;
    case (state_q)
      IDLE: begin
        if (exc_any) begin
          take_trap = 1'b1;
          state_d   = REQ;
        end else if (irq_take) begin
          take_trap = 1'b1;
          take_irq  = 1'b1;
          state_d   = REQ;
        end else if (mret_in) begin
          do_mret = 1'b1;
        end
      end
      REQ: begin
        if (trap_ack_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Vectored mode offsets interrupts only; target uses the pre-write mtvec.
  assign trap_target = {mtvec_q[XLEN-1:2], 2'b00} +
                       ((mtvec_q[0] && take_irq) ? XLEN'({irq_code, 2'b00}) : '0);

  assign wr_mstatus = csr_we_in && (csr_addr_in == ADDR_MSTATUS);
  assign wr_mie     = csr_we_in && (csr_addr_in == ADDR_MIE);
  assign wr_mtvec   = csr_we_in && (csr_addr_in == ADDR_MTVEC);
  assign wr_mepc    = csr_we_in && (csr_addr_in == ADDR_MEPC);
  assign wr_mcause  = csr_we_in && (csr_addr_in == ADDR_MCAUSE);
  assign wr_mtval   = csr_we_in && (csr_addr_in == ADDR_MTVAL);

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // CSR and trap target registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= RESET_MTVEC;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      trap_pc_q      <= '0;
    end else begin
      // mie and mtvec writes are never blocked by a simultaneous trap.
      if (wr_mie)   mie_q   <= {csr_wdata_in[11], csr_wdata_in[7], csr_wdata_in[3]};
      // Reserved MODE values 2/3 collapse to direct mode.
      if (wr_mtvec) mtvec_q <= {csr_wdata_in[XLEN-1:2], 1'b0, (csr_wdata_in[1:0] == 2'b01)};

      if (take_trap) begin
        mepc_q         <= {epc_in[XLEN-1:2], 2'b00};
        mcause_q       <= take_irq ? {1'b1, {(XLEN-6){1'b0}}, irq_code} : XLEN'(exc_code);
        mtval_q        <= take_irq ? '0 : tval_in;
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
        trap_pc_q      <= trap_target;
      end else begin
        if (wr_mepc)   mepc_q   <= {csr_wdata_in[XLEN-1:2], 2'b00};
        if (wr_mcause) mcause_q <= csr_wdata_in;
        if (wr_mtval)  mtval_q  <= csr_wdata_in;
        if (do_mret) begin
          mstatus_mie_q  <= mstatus_mpie_q;
          mstatus_mpie_q <= 1'b1;
        end else if (wr_mstatus) begin
          mstatus_mie_q  <= csr_wdata_in[3];
          mstatus_mpie_q <= csr_wdata_in[7];
        end
      end
    end
  end

  // CSR read mux; MPP is hardwired to machine mode.
  always_comb begin
    csr_rdata_out = '0;
    case (csr_addr_in)
      ADDR_MSTATUS: csr_rdata_out = XLEN'({2'b11, 3'b000, mstatus_mpie_q, 3'b000,
                                           mstatus_mie_q, 3'b000});
      ADDR_MIE:     csr_rdata_out = XLEN'({mie_q[2], 3'b000, mie_q[1], 3'b000,
                                           mie_q[0], 3'b000});
      ADDR_MTVEC:   csr_rdata_out = mtvec_q;
      ADDR_MEPC:    csr_rdata_out = mepc_q;
      ADDR_MCAUSE:  csr_rdata_out = mcause_q;
      ADDR_MTVAL:   csr_rdata_out = mtval_q;
      ADDR_MIP:     csr_rdata_out = XLEN'({irq_in[2], 3'b000, irq_in[1], 3'b000,
                                           irq_in[0], 3'b000});
      default:      csr_rdata_out = '0;
    endcase
  end

  assign trap_valid_out = (state_q == REQ);
  assign busy_out       = (state_q == REQ);
  assign trap_pc_out    = trap_pc_q;
  assign mret_pc_out    = mepc_q;

endmodule

// File: tb/tb_trap_arbiter.sv
module tb_trap_arbiter;

  logic        clk;
  logic        rst;
  logic [11:0] exc_req;
  logic [31:0] epc;
  logic [31:0] tval;
  logic [2:0]  irq;
  logic        mret;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        trap_ack;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic [31:0] mret_pc;
  logic        busy;

  int n_total = 0;
  int n_pass  = 0;

  trap_arbiter #(
    .XLEN(32),
    .NUM_EXC(12),
    .RESET_MTVEC(32'h0000_0100)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .exc_req_in    (exc_req),
    .epc_in        (epc),
    .tval_in       (tval),
    .irq_in        (irq),
    .mret_in       (mret),
    .csr_we_in     (csr_we),
    .csr_addr_in   (csr_addr),
    .csr_wdata_in  (csr_wdata),
    .csr_rdata_out (csr_rdata),
    .trap_ack_in   (trap_ack),
    .trap_valid_out(trap_valid),
    .trap_pc_out   (trap_pc),
    .mret_pc_out   (mret_pc),
    .busy_out      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [11:0] exc;
    logic [31:0] epc;
    logic [31:0] tval;
    logic [2:0]  irq;
    bit          mret;
    bit          ack;
    bit          we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [11:0] raddr;
    logic [31:0] exp_rd;
    bit          exp_v;
    logic [31:0] exp_pc;
    logic [31:0] exp_mepc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input logic [11:0] e, input logic [31:0] pc_i,
                     input logic [31:0] tv, input logic [2:0] iq, input bit mr,
                     input bit ak, input bit w, input logic [11:0] wa,
                     input logic [31:0] wd, input logic [11:0] ra,
                     input logic [31:0] xrd, input bit xv, input logic [31:0] xpc,
                     input logic [31:0] xmepc);
    vec_t v;
    v.rst = r; v.exc = e; v.epc = pc_i; v.tval = tv; v.irq = iq; v.mret = mr;
    v.ack = ak; v.we = w; v.waddr = wa; v.wdata = wd; v.raddr = ra;
    v.exp_rd = xrd; v.exp_v = xv; v.exp_pc = xpc; v.exp_mepc = xmepc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  initial begin
    logic [11:0] rd_addrs [7];
    logic [31:0] rd_exp   [7];

    rst = 1'b1; exc_req = '0; epc = '0; tval = '0; irq = '0; mret = 1'b0;
    csr_we = 1'b0; csr_addr = '0; csr_wdata = '0; trap_ack = 1'b0;

    //   rst exc     epc       tval     irq    mret ack we waddr   wdata     raddr   exp_rd        v  exp_pc    exp_mepc
    add(0, 12'h024, 32'h2000, 32'hDEAD, 3'b000, 0, 0, 0, 12'h000, 32'h0,    12'h342, 32'h2,        1, 32'h100, 32'h2000); // 1 exc, cause 2
    add(0, 12'h001, 32'h3000, 32'h1,    3'b000, 0, 0, 0, 12'h000, 32'h0,    12'h341, 32'h2000,     1, 32'h100, 32'h2000); // 2 REQ ignores exc
    add(0, 12'h000, 32'h0,    32'h0,    3'b000, 0, 0, 0, 12'h000, 32'h0,    12'h343, 32'hDEAD,     1, 32'h100, 32'h2000); // 3 hold
    add(0, 12'h000, 32'h0,    32'h0,    3'b000, 0, 0, 0, 12'h000, 32'h0,    12'h342, 32'h2,        1, 32'h100, 32'h2000); // 4 hold
    add(0, 12'h000, 32'h0,    32'h0,    3'b000, 0, 1, 0, 12'h000, 32'h0,    12'h342, 32'h2,        0, 32'h100, 32'h2000); // 5 ack
    add(0, 12'h000, 32'h0,    32'h0,    3'b000, 0, 0, 1, 12'h305, 32'h201,  12'h305, 32'h201,      0, 32'h100, 32'h2000); // 6 mtvec vectored
    add(0, 12'h000, 32'h0,    32'h0,    3'b000, 0, 0, 1, 12'h304, 32'hFFF,  12'h304, 32'h888,      0, 32'h100, 32'h2000); // 7 mie mask
    add(0, 12'h000, 32'h0,    32'h0,    3'b000, 0, 0, 1, 12'h305, 32'h203,  12'h305, 32'h200,      0, 32'h100, 32'h2000); // 8 MODE 3 -> 0
    add(0, 12'h000, 32'h0,    32'h0,    3'b000, 0, 0, 1, 12'h305, 32'h201,  12'h305, 32'h201,      0, 32'h100, 32'h2000); // 9
    add(0, 12'h000, 32'h0,    32'h0,    3'b111, 0, 0, 0, 12'h000, 32'h0,    12'h344, 32'h888,      0, 32'h100, 32'h2000); // 10 MIE=0 no trap
    add(0, 12'h000, 32'h0,    32'h0,    3'b111, 0, 0, 1, 12'h300, 32'h8,    12'h300, 32'h1808,     0, 32'h100, 32'h2000); // 11 enable MIE
    add(0, 12'h000, 32'h4004, 32'h77,   3'b111, 0, 0, 0, 12'h000, 32'h0,    12'h342, 32'h8000000B, 1, 32'h22C, 32'h4004); // 12 MEI
    add(0, 12'h000, 32'h0,    32'h0,    3'b111, 0, 1, 0, 12'h000, 32'h0,    12'h300, 32'h1880,     0, 32'h22C, 32'h4004); // 13 ack first REQ cycle
    add(0, 12'h000, 32'h5000, 32'h0,    3'b111, 0, 0, 0, 12'h000, 32'h0,    12'h343, 32'h0,        0, 32'h22C, 32'h4004); // 14 not retaken
    add(0, 12'h000, 32'h0,    32'h0,    3'b000, 1, 0, 0, 12'h000, 32'h0,    12'h300, 32'h1888,     0, 32'h22C, 32'h4004); // 15 mret
    add(0, 12'h000, 32'h6000, 32'h0,    3'b010, 0, 0, 0, 12'h000, 32'h0,    12'h342, 32'h80000007, 1, 32'h21C, 32'h6000); // 16 MTI
    add(0, 12'h000, 32'h0,    32'h0,    3'b000, 0, 1, 0, 12'h000, 32'h0,    12'h341, 32'h6000,     0, 32'h21C, 32'h6000); // 17 ack
    add(0, 12'h000, 32'h0,    32'h0,    3'b000, 1, 0, 0, 12'h000, 32'h0,    12'h300, 32'h1888,     0, 32'h21C, 32'h6000); // 18 mret
    add(0, 12'h000, 32'h6100, 32'h0,    3'b011, 0, 0, 0, 12'h000, 32'h0,    12'h342, 32'h80000003, 1, 32'h20C, 32'h6100); // 19 MSI over MTI
    add(0, 12'h000, 32'h0,    32'h0,    3'b000, 0, 1, 0, 12'h000, 32'h0,    12'h344, 32'h0,        0, 32'h20C, 32'h6100); // 20 ack
    add(0, 12'h800, 32'h7000, 32'h1234, 3'b000, 0, 0, 0, 12'h000, 32'h0,    12'h342, 32'hB,        1, 32'h200, 32'h7000); // 21 exc unvectored
    add(0, 12'h000, 32'h0,    32'h0,    3'b000, 0, 1, 0, 12'h000, 32'h0,    12'h343, 32'h1234,     0, 32'h200, 32'h7000); // 22 ack
    add(0, 12'h000, 32'h0,    32'h0,    3'b000, 0, 0, 1, 12'h300, 32'h8,    12'h300, 32'h1808,     0, 32'h200, 32'h7000); // 23 MIE=1
    add(0, 12'h010, 32'h8000, 32'h99,   3'b000, 1, 0, 1, 12'h341, 32'h55,   12'h341, 32'h8000,     1, 32'h200, 32'h8000); // 24 exc+mret+write
    add(0, 12'h000, 32'h0,    32'h0,    3'b000, 0, 0, 0, 12'h000, 32'h0,    12'h300, 32'h1880,     1, 32'h200, 32'h8000); // 25 MIE cleared
    add(0, 12'h000, 32'h0,    32'h0,    3'b000, 0, 0, 1, 12'h343, 32'hABC,  12'h343, 32'hABC,      1, 32'h200, 32'h8000); // 26 write in REQ
    add(1, 12'h000, 32'h0,    32'h0,    3'b000, 0, 0, 0, 12'h000, 32'h0,    12'h305, 32'h100,      0, 32'h0,   32'h0);    // 27 reset in REQ
    add(0, 12'h000, 32'h0,    32'h0,    3'b000, 0, 0, 0, 12'h000, 32'h0,    12'h342, 32'h0,        0, 32'h0,   32'h0);    // 28
    add(0, 12'h000, 32'h0,    32'h0,    3'b000, 0, 0, 0, 12'h000, 32'h0,    12'h300, 32'h1800,     0, 32'h0,   32'h0);    // 29
    add(0, 12'h000, 32'h0,    32'h0,    3'b000, 0, 0, 0, 12'h000, 32'h0,    12'h304, 32'h0,        0, 32'h0,   32'h0);    // 30

    // Reset and read-back of every CSR
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd_addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344};
    rd_exp   = '{32'h1800, 32'h0, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 7; i++) begin
      csr_addr = rd_addrs[i];
      #1;
      chk($sformatf("reset_csr_%03h", rd_addrs[i]), csr_rdata, rd_exp[i]);
    end
    csr_addr = 12'h7C0;
    #1;
    chk("unmapped_csr", csr_rdata, 32'h0);
    chk("reset_valid", {31'b0, trap_valid}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_trap_pc", trap_pc, 32'h0);
    chk("reset_mret_pc", mret_pc, 32'h0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst       = vecs[i].rst;
      exc_req   = vecs[i].exc;
      epc       = vecs[i].epc;
      tval      = vecs[i].tval;
      irq       = vecs[i].irq;
      mret      = vecs[i].mret;
      trap_ack  = vecs[i].ack;
      csr_we    = vecs[i].we;
      csr_addr  = vecs[i].we ? vecs[i].waddr : vecs[i].raddr;
      csr_wdata = vecs[i].wdata;
      @(negedge clk);
      rst = 1'b0; exc_req = '0; mret = 1'b0; trap_ack = 1'b0; csr_we = 1'b0;
      csr_addr = vecs[i].raddr;
      #1;
      chk($sformatf("v%0d_rdata", i + 1), csr_rdata, vecs[i].exp_rd);
      chk($sformatf("v%0d_valid", i + 1), {31'b0, trap_valid}, {31'b0, vecs[i].exp_v});
      chk($sformatf("v%0d_busy", i + 1), {31'b0, busy}, {31'b0, vecs[i].exp_v});
      chk($sformatf("v%0d_trap_pc", i + 1), trap_pc, vecs[i].exp_pc);
      chk($sformatf("v%0d_mret_pc", i + 1), mret_pc, vecs[i].exp_mepc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/trap_arbiter.md
# trap_arbiter

Parametrised machine-mode trap controller for the RV32 core. It replaces the fixed 12-level exception encoder and separate bus-interrupt decoder with one arbiter. The arbiter selects one trap per cycle from NUM_EXC synchronous exception sources and three machine interrupts (MSI, MTI, MEI). It commits mepc, mcause, mtval and mstatus, then hands the trap target PC to the fetch stage with a valid/ack handshake. It sits between the pipeline's exception collection logic and fetch, and owns the trap CSRs behind a single-cycle CSR port.

## Interface
- XLEN, 32, datapath and CSR width.
- NUM_EXC, 12, number of exception sources, 1..16. Bit i has cause code i. Lower index means higher priority.
- RESET_MTVEC, 32'h0000_0100, mtvec reset value.

- clk_in  in  1  clock. One clock domain. Reset is synchronous and active-high.
- rst_in  in  1  synchronous active-high reset.
- exc_req_in  in  NUM_EXC  exception requests. Valid for the cycle presented; not held.
- epc_in  in  XLEN  PC of the faulting or interrupted instruction.
- tval_in  in  XLEN  trap value accompanying exc_req_in.
- irq_in  in  3  level interrupts {meip, mtip, msip}.
- mret_in  in  1  one-cycle MRET retire pulse.
- csr_we_in  in  1  CSR write strobe.
- csr_addr_in  in  12  CSR address.
- csr_wdata_in  in  XLEN  CSR write data.
- csr_rdata_out  out  XLEN  combinational read of csr_addr_in. Returns 0 for unmapped addresses.
- trap_ack_in  in  1  fetch has accepted trap_pc_out.
- trap_valid_out  out  1  trap redirect pending.
- trap_pc_out  out  XLEN  handler address; stable while trap_valid_out is high.
- mret_pc_out  out  XLEN  always equals mepc.
- busy_out  out  1  high in state REQ; the pipeline stalls on it.

## Operation
- CSRs:
  - mstatus 0x300: MIE is bit 3 and MPIE is bit 7, both read/write. MPP (12:11) reads 2'b11. All other bits read 0.
  - mie 0x304: bits 3, 7 and 11 are writable; other bits read 0.
  - mtvec 0x305: read/write. MODE is bits 1:0; values 2 and 3 read back as 0.
  - mepc 0x341: bits 1:0 read 0.
  - mcause 0x342 and mtval 0x343: read/write.
  - mip 0x344: read-only. Value is {irq_in[2]<<11, irq_in[1]<<7, irq_in[0]<<3}.
- FSM states are IDLE and REQ.
- In IDLE, priority from highest to lowest:
  1. Any exc_req_in bit set. Take the lowest set index i. Capture mepc ← epc_in, mcause ← i, mtval ← tval_in. All other simultaneous requests are dropped; the pipeline replays them.
  2. Otherwise, if MIE=1 and (mie & mip) ≠ 0, take an interrupt in the order MEI(11) > MSI(3) > MTI(7). Capture mcause ← {1, code}, mepc ← epc_in, mtval ← 0.
  3. Otherwise, if mret_in: MIE ← MPIE, MPIE ← 1. State stays IDLE.
- On trap capture (steps 1 and 2):
  - MPIE ← MIE, MIE ← 0.
  - trap_pc_out ← mtvec base with bits 1:0 cleared. If MODE=1 and the trap is an interrupt, add 4×code.
  - Go to REQ.
- In REQ:
  - trap_valid_out = 1.
  - exc_req_in, irq_in and mret_in are ignored.
  - When trap_ack_in is high, go to IDLE.
- CSR write in the same cycle as a trap capture: the trap wins for mepc, mcause, mtval and mstatus. Writes to mtvec and mie still apply. trap_pc_out uses the pre-write mtvec.
- CSR writes in REQ apply normally.
- mret_in together with an exception or taken interrupt: the trap wins and the MRET is dropped.
- rst_in, even in REQ, forces IDLE. Reset values:
  - mstatus = 0, mie = 0, mepc = 0, mcause = 0, mtval = 0, mtvec = RESET_MTVEC.
  - trap_valid_out = 0, busy_out = 0, trap_pc_out = 0.
  - A pending trap is discarded.

## Timing
- Request in cycle N: CSRs update and trap_valid_out and busy_out assert at edge N+1.
- trap_ack_in high in cycle M (in REQ): trap_valid_out deasserts at edge M+1. Ack may arrive in the first REQ cycle.
- Minimum spacing between two traps is 2 cycles.
- trap_pc_out holds its value until the next capture.
- MRET effect is visible on csr_rdata_out one cycle after mret_in.
- An interrupt enabled by a CSR write in cycle N can first be taken in cycle N+1.
- All registers update only on the rising edge of clk_in.

## Test plan
- Reset, then read every CSR. mtvec = 0x100, all others 0, mstatus.MPP reads 3, trap_valid_out = 0.
- exc_req_in = 0x024, epc_in = 0x2000, tval_in = 0xDEAD.
  - Next cycle: mcause = 2, mepc = 0x2000, mtval = 0xDEAD, trap_pc_out = 0x100, trap_valid_out = 1.
  - Holding trap_ack_in low for 3 cycles keeps all outputs stable. Ack returns to IDLE one cycle later.
- Setup: write mtvec = 0x201, mie = 0x888, mstatus = 0x8. Then raise irq_in = 3'b111.
  - mcause = 0x8000000B, trap_pc_out = 0x22C, MIE = 0, MPIE = 1.
  - While MIE = 0, irq_in is not retaken.
- Interrupt with MIE = 0: no trap.
  - Then write mstatus = 0x8 and keep irq_in high: the trap is taken exactly one cycle after the write.
- Exception and mret_in together with a CSR write of mepc = 0x55: the exception's epc is kept, mret is ignored, MIE is cleared.
- In REQ, assert rst_in: trap_valid_out = 0 next cycle and all CSRs return to their reset values.
